// File: rtl/level_pkg.sv
// Shared types and helpers for the level sensor filter.
package level_pkg;

  typedef logic [2:0] lvl_t;

  localparam lvl_t LVL_EMPTY = 3'd0;
  localparam lvl_t LVL_FULL  = 3'd4;

  function automatic int unsigned ms_to_cycles(input int unsigned hz, input int unsigned ms);
    int unsigned c;
    c = hz / 1000 * ms;
    return (c == 0) ? 1 : c;
  endfunction

endpackage

// File: rtl/level_channel_filter.sv
// One tank channel: probe synchroniser, thermometer decode, stability filter
// and invalid-pattern fault detection.
module level_channel_filter
  import level_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned FAULT_CYCLES  = 10,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] probe,
  output lvl_t       lvl,
  output logic       committed,
  output logic       commit,
  output logic       change,
  output logic       fault
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned IW = $clog2(FAULT_CYCLES + 1);
  localparam logic [FW-1:0] STAB_MAX  = FW'(FILTER_CYCLES - 1);
  localparam logic [IW-1:0] INV_MAX   = IW'(FAULT_CYCLES);
  localparam logic [IW-1:0] INV_LAST  = IW'(FAULT_CYCLES - 1);

  logic [3:0]    sync1, sync2;
  logic [1:0]    fill;
  logic [3:0]    pat;
  logic          pat_valid;
  lvl_t          pat_code;
  lvl_t          cand;
  logic          cand_vld;
  logic [FW-1:0] stab;
  logic [IW-1:0] inv;
  logic          active;

  // Filtering waits until the synchroniser holds real samples, so the first
  // commit after reset always takes the full filter latency.
  assign active = fill[1];

  always_comb begin
    pat       = ACTIVE_LOW ? ~sync2 : sync2;
    pat_valid = (pat & (pat + 4'd1)) == 4'd0;
    pat_code  = lvl_t'($countones(pat));
    commit    = active & pat_valid & cand_vld & (pat_code == cand) & (stab == STAB_MAX);
    change    = commit & (cand != lvl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      fill      <= '0;
      cand      <= LVL_EMPTY;
      cand_vld  <= 1'b0;
      stab      <= '0;
      inv       <= '0;
      lvl       <= LVL_EMPTY;
      committed <= 1'b0;
      fault     <= 1'b0;
    end else begin
      sync1 <= probe;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (active) begin
        if (!pat_valid) begin
          stab <= '0;
          if (inv != INV_MAX) inv <= inv + IW'(1);
          if (inv == INV_LAST) fault <= 1'b1;
        end else begin
          inv <= '0;
          if (!cand_vld || pat_code != cand) begin
            cand     <= pat_code;
            cand_vld <= 1'b1;
            stab     <= '0;
          end else if (stab != STAB_MAX) begin
            stab <= stab + FW'(1);
          end
          if (commit) begin
            lvl       <= cand;
            committed <= 1'b1;
            fault     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/level_sensor_filter.sv
// Two-tank level sensor filter: per-tank channels plus combined valid/change flags.
module level_sensor_filter
  import level_pkg::*;
#(
  parameter int unsigned CLK_HZ            = 25_000_000,
  parameter int unsigned FILTER_MS         = 20,
  parameter int unsigned FAULT_MS          = 500,
  parameter bit          ACTIVE_LOW_PROBES = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] probe_inf,
  input  logic [3:0] probe_sup,
  output logic [2:0] lvl_inf,
  output logic [2:0] lvl_sup,
  output logic       lvl_valid,
  output logic       lvl_chg,
  output logic [1:0] sensor_fault
);

  localparam int unsigned FILTER_CYCLES = ms_to_cycles(CLK_HZ, FILTER_MS);
  localparam int unsigned FAULT_CYCLES  = ms_to_cycles(CLK_HZ, FAULT_MS);

  logic com_inf, com_sup;
  logic commit_inf, commit_sup;
  logic chg_inf, chg_sup;
  logic flt_inf, flt_sup;

  level_channel_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .FAULT_CYCLES (FAULT_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW_PROBES)
  ) u_inf (
    .clk      (clk),
    .rst_n    (rst_n),
    .probe    (probe_inf),
    .lvl      (lvl_inf),
    .committed(com_inf),
    .commit   (commit_inf),
    .change   (chg_inf),
    .fault    (flt_inf)
  );

  level_channel_filter #(
    .FILTER_CYCLES(FILTER_CYCLES),
    .FAULT_CYCLES (FAULT_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW_PROBES)
  ) u_sup (
    .clk      (clk),
    .rst_n    (rst_n),
    .probe    (probe_sup),
    .lvl      (lvl_sup),
    .committed(com_sup),
    .commit   (commit_sup),
    .change   (chg_sup),
    .fault    (flt_sup)
  );

  assign sensor_fault = {flt_sup, flt_inf};

  // Flags are registered from the channels' commit decisions so they line up
  // with the edge on which the level registers update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_valid <= 1'b0;
      lvl_chg   <= 1'b0;
    end else begin
      lvl_valid <= lvl_valid | ((com_inf | commit_inf) & (com_sup | commit_sup));
      lvl_chg   <= chg_inf | chg_sup;
    end
  end

endmodule

// File: tb/tb_level_sensor_filter.sv
// Directed and randomized bench for level_sensor_filter with a reference model.
module tb_level_sensor_filter;

  localparam int FILT  = 4;
  localparam int FAULT = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] probe_inf, probe_sup;
  logic [2:0] lvl_inf, lvl_sup;
  logic       lvl_valid, lvl_chg;
  logic [1:0] sensor_fault;

  logic [3:0] probe_inf2, probe_sup2;
  logic [2:0] lvl_inf2, lvl_sup2;
  logic       lvl_valid2, lvl_chg2;
  logic [1:0] sensor_fault2;

  always #5 clk = ~clk;

  level_sensor_filter #(
    .CLK_HZ(1000), .FILTER_MS(4), .FAULT_MS(10), .ACTIVE_LOW_PROBES(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .probe_inf(probe_inf), .probe_sup(probe_sup),
    .lvl_inf(lvl_inf), .lvl_sup(lvl_sup), .lvl_valid(lvl_valid),
    .lvl_chg(lvl_chg), .sensor_fault(sensor_fault)
  );

  level_sensor_filter #(
    .CLK_HZ(1000), .FILTER_MS(4), .FAULT_MS(10), .ACTIVE_LOW_PROBES(1'b1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .probe_inf(probe_inf2), .probe_sup(probe_sup2),
    .lvl_inf(lvl_inf2), .lvl_sup(lvl_sup2), .lvl_valid(lvl_valid2),
    .lvl_chg(lvl_chg2), .sensor_fault(sensor_fault2)
  );

  int total = 0;
  int bad   = 0;
  int chg_cnt;

  // Reference model: edge index since reset release, raw inputs sampled per edge,
  // candidate code and the edge at which its stability window started.
  int         m;
  logic [3:0] hist [2][2048];
  int         cand [2];
  int         start [2];
  int         inv_run [2];
  int         mlvl [2];
  bit         mcom [2];
  bit         mflt [2];
  bit         mchg, mval;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = 0;
    for (int c = 0; c < 2; c++) begin
      cand[c] = -1; start[c] = 0; inv_run[c] = 0;
      mlvl[c] = 0; mcom[c] = 0; mflt[c] = 0;
    end
    mchg = 0; mval = 0;
  endtask

  task automatic model_edge();
    logic [3:0] p;
    mchg = 0;
    if (m >= 3) begin
      for (int c = 0; c < 2; c++) begin
        p = hist[c][m-2];
        if (!(p inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) begin
          start[c] = m;
          if (inv_run[c] < FAULT) inv_run[c]++;
          if (inv_run[c] == FAULT) mflt[c] = 1;
        end else begin
          inv_run[c] = 0;
          if (cand[c] != $countones(p)) begin
            cand[c]  = $countones(p);
            start[c] = m;
          end else if (m - start[c] >= FILT) begin
            if (mlvl[c] != cand[c]) mchg = 1;
            mlvl[c] = cand[c];
            mcom[c] = 1;
            mflt[c] = 0;
          end
        end
      end
    end
    mval = mcom[0] && mcom[1];
  endtask

  task automatic check_all();
    chk("lvl_inf", 8'(lvl_inf), 8'(mlvl[0]));
    chk("lvl_sup", 8'(lvl_sup), 8'(mlvl[1]));
    chk("lvl_valid", 8'(lvl_valid), 8'(mval));
    chk("lvl_chg", 8'(lvl_chg), 8'(mchg));
    chk("sensor_fault", 8'(sensor_fault), 8'({mflt[1], mflt[0]}));
  endtask

  // Called at a negedge: drive, take one rising edge, then compare at the next negedge.
  task automatic step(input logic [3:0] pi, input logic [3:0] ps);
    probe_inf = pi;
    probe_sup = ps;
    @(posedge clk);
    m++;
    hist[0][m] = pi;
    hist[1][m] = ps;
    model_edge();
    @(negedge clk);
    if (lvl_chg === 1'b1) chg_cnt++;
    check_all();
  endtask

  function automatic logic [3:0] rand_pat(output bit valid);
    logic [3:0] p;
    int k;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, 4);
      p = 4'((1 << k) - 1);
      valid = 1;
    end else begin
      do p = 4'($urandom_range(0, 15));
      while (p inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
      valid = 0;
    end
    return p;
  endfunction

  initial begin
    logic [3:0] rp [2];
    int         rem [2];
    bit         v;

    rst_n      = 1'b0;
    probe_inf  = 4'b0011;
    probe_sup  = 4'b0001;
    probe_inf2 = 4'b1000;
    probe_sup2 = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_lvl_inf", 8'(lvl_inf), 8'd0);
    chk("reset_lvl_sup", 8'(lvl_sup), 8'd0);
    chk("reset_valid", 8'(lvl_valid), 8'd0);
    chk("reset_chg", 8'(lvl_chg), 8'd0);
    chk("reset_fault", 8'(sensor_fault), 8'd0);
    rst_n = 1'b1;

    // First commit lands exactly on the 7th edge after release.
    chg_cnt = 0;
    repeat (6) step(4'b0011, 4'b0001);
    chk("first_pre_lvl_inf", 8'(lvl_inf), 8'd0);
    chk("first_pre_valid", 8'(lvl_valid), 8'd0);
    step(4'b0011, 4'b0001);
    chk("first_lvl_inf", 8'(lvl_inf), 8'd2);
    chk("first_lvl_sup", 8'(lvl_sup), 8'd1);
    chk("first_valid", 8'(lvl_valid), 8'd1);
    repeat (5) step(4'b0011, 4'b0001);
    chk("first_chg_count", 8'(chg_cnt), 8'd1);

    // Glitch that reverts before commit.
    chg_cnt = 0;
    repeat (2) step(4'b0111, 4'b0001);
    repeat (10) step(4'b0011, 4'b0001);
    chk("glitch_lvl_inf", 8'(lvl_inf), 8'd2);
    chk("glitch_chg_count", 8'(chg_cnt), 8'd0);

    // Invalid upper pattern: fault on 10th invalid sample, cleared by next commit.
    repeat (11) step(4'b0011, 4'b0101);
    chk("fault_pre", 8'(sensor_fault), 8'd0);
    step(4'b0011, 4'b0101);
    chk("fault_set", 8'(sensor_fault), 8'd2);
    chk("fault_hold_lvl_sup", 8'(lvl_sup), 8'd1);
    repeat (6) step(4'b0011, 4'b0011);
    chk("fault_still", 8'(sensor_fault), 8'd2);
    chk("fault_frozen_lvl_sup", 8'(lvl_sup), 8'd1);
    step(4'b0011, 4'b0011);
    chk("fault_clear", 8'(sensor_fault), 8'd0);
    chk("fault_commit_lvl_sup", 8'(lvl_sup), 8'd2);

    // Simultaneous change on both channels.
    chg_cnt = 0;
    repeat (6) step(4'b1111, 4'b0001);
    chk("both_pre_inf", 8'(lvl_inf), 8'd2);
    step(4'b1111, 4'b0001);
    chk("both_lvl_inf", 8'(lvl_inf), 8'd4);
    chk("both_lvl_sup", 8'(lvl_sup), 8'd1);
    chk("both_chg", 8'(lvl_chg), 8'd1);
    repeat (4) step(4'b1111, 4'b0001);
    chk("both_chg_count", 8'(chg_cnt), 8'd1);

    // Active-low instance has seen 1000/1111 since reset.
    chk("al_lvl_inf", 8'(lvl_inf2), 8'd3);
    chk("al_lvl_sup", 8'(lvl_sup2), 8'd0);
    chk("al_valid", 8'(lvl_valid2), 8'd1);

    // Reset mid-filter with the stability counter at 2.
    repeat (5) step(4'b0011, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_lvl_inf", 8'(lvl_inf), 8'd0);
    chk("midrst_lvl_sup", 8'(lvl_sup), 8'd0);
    chk("midrst_valid", 8'(lvl_valid), 8'd0);
    chk("midrst_fault", 8'(sensor_fault), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(4'b0011, 4'b0001);
    chk("midrst_no_early", 8'(lvl_inf), 8'd0);
    step(4'b0011, 4'b0001);
    chk("midrst_commit", 8'(lvl_inf), 8'd2);

    // Randomized phase against the model.
    rem[0] = 0;
    rem[1] = 0;
    rp[0]  = 4'b0011;
    rp[1]  = 4'b0001;
    for (int n = 0; n < 900; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          rp[c]  = rand_pat(v);
          rem[c] = v ? $urandom_range(1, 9) : $urandom_range(1, 14);
        end
        rem[c]--;
      end
      step(rp[0], rp[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/level_sensor_filter.md
LEVEL_SENSOR_FILTER -- requirements
Module: level_sensor_filter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 25_000_000, clock frequency in Hz.
REQ-002 The block SHALL have parameter FILTER_MS, default 20, stability time in ms before a level code is committed; FILTER_CYCLES = CLK_HZ/1000*FILTER_MS, minimum 1.
REQ-003 The block SHALL have parameter FAULT_MS, default 500, persistence time in ms of an invalid probe pattern before fault; FAULT_CYCLES = CLK_HZ/1000*FAULT_MS, greater than FILTER_CYCLES.
REQ-004 The block SHALL have parameter ACTIVE_LOW_PROBES, default 1, meaning raw probe 0 V = wet; when 1, raw bits are inverted after synchronisation.
REQ-005 Port clk, input, 1 bit: single system clock.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port probe_inf, input, 4 bits: raw lower-tank probes, bit0=25 %, bit3=100 %, asynchronous to clk.
REQ-008 Port probe_sup, input, 4 bits: raw upper-tank probes, same bit order.
REQ-009 Port lvl_inf, output, 3 bits: filtered lower level code 0..4, feeds the pump controller.
REQ-010 Port lvl_sup, output, 3 bits: filtered upper level code 0..4.
REQ-011 Port lvl_valid, output, 1 bit: high once both channels have committed at least one code since reset.
REQ-012 Port lvl_chg, output, 1 bit: one-cycle pulse on any cycle in which either committed code changes.
REQ-013 Port sensor_fault, output, 2 bits: bit0 lower channel, bit1 upper channel, invalid-pattern fault.

Function
REQ-014 Each probe bit SHALL pass through a 2-flop synchroniser before any use.
REQ-015 A synchronised, polarity-corrected pattern SHALL be valid only if thermometer-coded (0000, 0001, 0011, 0111, 1111); valid code = number of set bits.
REQ-016 Each channel SHALL hold a candidate code and a stability counter: a valid code differing from the candidate loads the candidate and clears the counter; an equal code increments the counter, saturating at FILTER_CYCLES-1.
REQ-017 When the counter equals FILTER_CYCLES-1 with an equal code, the channel SHALL commit the candidate to its output register.
REQ-018 Latency SHALL be exactly FILTER_CYCLES+3 clk edges from a stable raw change to the output update.
REQ-019 A raw change that reverts before commit SHALL produce no output change and no lvl_chg pulse.
REQ-020 An invalid pattern SHALL clear the stability counter, leave the candidate and committed output unchanged, and increment a separate invalid counter saturating at FAULT_CYCLES.
REQ-021 The sensor_fault bit SHALL assert on the cycle the invalid counter reaches FAULT_CYCLES.
REQ-022 The invalid counter SHALL clear on any valid pattern, but sensor_fault SHALL deassert only at the next commit of that channel.
REQ-023 The committed output SHALL freeze while sensor_fault is high.
REQ-024 lvl_chg SHALL pulse only when the committed value differs from the previous value; simultaneous commits on both channels produce one pulse.
REQ-025 All outputs SHALL be registered; no combinational path from probe inputs to outputs.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously clear synchronisers, candidates, counters, lvl_inf=0, lvl_sup=0, lvl_valid=0, lvl_chg=0, sensor_fault=0.
REQ-027 Reset mid-filter SHALL discard any pending candidate; filtering restarts from count 0 after release.
REQ-028 Release SHALL be sampled on the clk edge; the first commit after release occurs no earlier than FILTER_CYCLES+3 edges.

Structure
REQ-029 Package level_pkg SHALL hold typedef lvl_t (3 bits), LVL_EMPTY=0 and LVL_FULL=4 constants, and a function converting ms to cycles.
REQ-030 Per-tank logic SHALL be sub-module level_channel_filter (sync, encode, filter, fault), instantiated twice; the top combines lvl_valid and lvl_chg.

Verification
Use CLK_HZ=1000, FILTER_MS=4, FAULT_MS=10, ACTIVE_LOW_PROBES=0, giving FILTER_CYCLES=4 and FAULT_CYCLES=10.
REQ-031 Reset, then probe_inf=0011 and probe_sup=0001 held -> lvl_inf=2 and lvl_sup=1 after 7 edges, lvl_valid=1, one lvl_chg pulse.
REQ-032 probe_inf 0011->0111 for 2 cycles then back -> lvl_inf stays 2, no lvl_chg.
REQ-033 probe_sup=0101 held 12 cycles -> lvl_sup holds old value, sensor_fault[1]=1 at the 10th invalid cycle; then 0011 held -> fault clears with lvl_sup=2 commit.
REQ-034 ACTIVE_LOW_PROBES=1, probe_inf=1000 -> lvl_inf=3.
REQ-035 rst_n pulsed low mid-filter (counter=2) -> outputs 0 immediately, no commit before 7 edges after release.
REQ-036 Both channels change in the same cycle -> both commit on the same edge, single lvl_chg pulse.
